serial_alu: RTL
===============

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result bit count (legal 4..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port start  input  1  request operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port sel  input  2  op select: 00 AND, 01 OR, 10 ADD/SUB, 11 SLT; captured on accepted start.
REQ-008 SHALL have port inv  input  1  invert B and carry-in 1 for sel=10; captured on accepted start.
REQ-009 SHALL have port busy  output  1  high in RUN and SLT_FIX.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  WIDTH  operation result, held until next accepted start.
REQ-012 SHALL have port cout  output  1  carry out of MSB.
REQ-013 SHALL have port zero  output  1  high when result is all zeros.

Function
REQ-014 SHALL implement states IDLE, RUN, SLT_FIX, DONE; bit counter of clog2(WIDTH) bits, carry flip-flop, shift registers for A, B, result.
REQ-015 SHALL, on edge with start=1 in IDLE or DONE, capture a, b, sel, inv, clear counter, load carry (1 if sel=11 or (sel=10 and inv=1), else 0), enter RUN.
REQ-016 SHALL, in RUN, process one bit per clock LSB first: bi = B bit XOR effective-inv (effective-inv = inv for 10, forced 1 for 11, 0 for 00/01); sum = Ai^bi^carry; carry <= majority(Ai,bi,carry).
REQ-017 SHALL shift into result MSB: Ai&Bi for 00, Ai|Bi for 01 (raw B, never inverted), sum for 10 and 11.
REQ-018 SHALL leave RUN after exactly WIDTH bit-clocks: to SLT_FIX if sel=11, else DONE.
REQ-019 SHALL, in SLT_FIX, capture set = sum of MSB (no overflow correction) and write result = {WIDTH-1 zeros, set}; next state DONE.
REQ-020 SHALL assert done for exactly one cycle in DONE; DONE -> RUN if start=1, else IDLE.
REQ-021 SHALL give latency: start accepted at edge k -> done high in cycle after edge k+WIDTH+1 (non-SLT), k+WIDTH+2 (SLT).
REQ-022 SHALL drive cout = final carry for 10/11, 0 for 00/01; updated with result.
REQ-023 SHALL ignore start while busy=1; captured operands unchanged.
REQ-024 SHALL keep result, cout, zero stable from DONE until the next accepted start, then keep them unchanged until the new DONE.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, force IDLE, busy=0, done=0, result=0, cout=0, zero=1, counter=0, carry=0 (and ovf=0 when enabled).
REQ-026 SHALL give rst priority over start; reset mid-RUN aborts with no done pulse.

Configuration
REQ-027 SHALL, with SERIAL_ALU_OVF_EN defined, add output ovf (1 bit) = carry into MSB XOR carry out of MSB for sel=10, 0 otherwise, and correct SLT set = MSB sum XOR that overflow.
REQ-028 SHALL, without SERIAL_ALU_OVF_EN, have no ovf port and compute SLT set per REQ-019.

Verification
REQ-029 SHALL test ADD, WIDTH=32: a=0x7FFFFFFF, b=1, sel=10, inv=0 -> result 0x80000000, cout=0, done 33 cycles after start (ovf=1 if enabled).
REQ-030 SHALL test SUB: a=5, b=5, sel=10, inv=1 -> result 0, zero=1, cout=1.
REQ-031 SHALL test SLT: a=3, b=7, sel=11 -> result 1, done 34 cycles after start; a=0x80000000, b=1 -> result 0 without macro, 1 with SERIAL_ALU_OVF_EN.
REQ-032 SHALL test AND/OR with inv=1: a=0xF0F0F0F0, b=0xFF00FF00 -> sel=00 0xF000F000, sel=01 0xFFF0FFF0, cout=0.
REQ-033 SHALL test control: start pulsed mid-RUN is ignored; rst at bit 10 -> no done, result=0; start held in DONE -> back-to-back op, done pulses each op.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU processing one operand bit per clock, LSB first.
//
// Operations (sel): 00 AND, 01 OR, 10 ADD/SUB (inv=1 subtracts), 11 SLT
// (signed a < b, computed as a + ~b + 1 and then reduced to one bit).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request an operation; sampled only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   sel    in   2-bit op select, captured on an accepted start
//   inv    in   invert B with carry-in 1 for ADD/SUB, captured on start
//   busy   out  high while the operation is in progress (RUN, SLT_FIX)
//   done   out  one-cycle pulse, result/cout/zero valid
//   result out  WIDTH-bit result, held until the next operation completes
//   cout   out  carry out of the MSB (ADD/SUB and SLT), else 0
//   zero   out  result is all zeros
//   ovf    out  signed overflow for ADD/SUB (only with SERIAL_ALU_OVF_EN)
//
// Configuration macro: SERIAL_ALU_OVF_EN adds the ovf port and makes SLT
// correct for signed overflow (set = MSB sum XOR overflow).
//
// Timing: start accepted at edge k; bits are processed on edges
// k+1..k+WIDTH; one extra RUN cycle hands off to DONE (edge k+WIDTH+1) or
// to SLT_FIX (DONE at edge k+WIDTH+2).

module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;

  // Control state
  logic [CW-1:0] cnt;
  logic          carry;
  logic          fin;

  // Captured operands and result shift register (no reset needed)
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       op;
  logic             inv_q;
`ifdef SERIAL_ALU_OVF_EN
  logic             cin_msb;
`endif

  logic accept;
  logic processing;
  logic eff_inv;
  logic bi;
  logic sum;
  logic nxt_carry;
  logic res_bit;
  logic slt_set;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign processing = (state == RUN) && !fin;

  // One full-adder slice on the current LSBs
  always_comb begin
    eff_inv   = 1'b0;
    bi        = 1'b0;
    sum       = 1'b0;
    nxt_carry = 1'b0;
    res_bit   = 1'b0;
    eff_inv   = (op == 2'b11) || ((op == 2'b10) && inv_q);
    bi        = b_sr[0] ^ eff_inv;
    sum       = a_sr[0] ^ bi ^ carry;
    nxt_carry = (a_sr[0] & bi) | (a_sr[0] & carry) | (bi & carry);
    // Logic ops use the raw B bit; inv only affects the adder path
    case (op)
      2'b00:   res_bit = a_sr[0] & b_sr[0];
      2'b01:   res_bit = a_sr[0] | b_sr[0];
      default: res_bit = sum;
    endcase
  end

  // SLT reduces the subtraction to its sign bit (the MSB sum, which is the
  // top of the result shift register once all bits are in).
  always_comb begin
    slt_set = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
    slt_set = res_sr[WIDTH-1] ^ (cin_msb ^ carry);
`else
    slt_set = res_sr[WIDTH-1];
`endif
  end

  // Datapath: operand capture and bit shifting
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      a_sr  <= a;
      b_sr  <= b;
      op    <= sel;
      inv_q <= inv;
    end else if (processing) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {res_bit, res_sr[WIDTH-1:1]};
`ifdef SERIAL_ALU_OVF_EN
      if (cnt == LAST) cin_msb <= carry;
`endif
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b1;
      cnt    <= '0;
      carry  <= 1'b0;
      fin    <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            fin   <= 1'b0;
            carry <= (sel == 2'b11) || ((sel == 2'b10) && inv);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          if (!fin) begin
            carry <= nxt_carry;
            if (cnt == LAST) begin
              cnt <= '0;
              fin <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (op == 2'b11) begin
            state <= SLT_FIX;
          end else begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_sr;
            cout   <= op[1] & carry;
            zero   <= (res_sr == '0);
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= (op == 2'b10) & (cin_msb ^ carry);
`endif
          end
        end

        SLT_FIX: begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= {{(WIDTH-1){1'b0}}, slt_set};
          cout   <= carry;
          zero   <= !slt_set;
`ifdef SERIAL_ALU_OVF_EN
          ovf    <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
